// File: rtl/seq_pkg.sv
// Shared types and defaults for the serial-scan controller and its matcher.
package seq_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int         DEF_W     = 8;
    localparam int         DEF_CNT_W = 8;
    localparam logic [7:0] DEF_PAT   = 8'b1101_0011;

endpackage

// File: rtl/seq_scan_ctrl_if.sv
// Parallel-in / serial-out bus of the scan controller, plus pattern config and match status.
interface seq_scan_ctrl_if
    import seq_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int CNT_W = DEF_CNT_W
);
    logic             IN_VALID;
    logic [W-1:0]     IN_DATA;
    logic             IN_READY;
    logic             CFG_WE;
    logic [W-1:0]     CFG_PAT;
    logic             DOUT;
    logic             DVAL;
    logic             HIT;
    logic [CNT_W-1:0] HIT_CNT;
    logic             BUSY;

    modport master (
        output IN_VALID, IN_DATA, CFG_WE, CFG_PAT,
        input  IN_READY, DOUT, DVAL, HIT, HIT_CNT, BUSY
    );

    modport slave (
        input  IN_VALID, IN_DATA, CFG_WE, CFG_PAT,
        output IN_READY, DOUT, DVAL, HIT, HIT_CNT, BUSY
    );
endinterface

// File: rtl/seq_match.sv
// Sliding-window pattern matcher on the serial stream: overlapping hits, saturating count.
module seq_match
    import seq_pkg::*;
#(
    parameter int           W       = DEF_W,
    parameter int           CNT_W   = DEF_CNT_W,
    parameter logic [W-1:0] PAT_RST = DEF_PAT
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             sbit,
    input  logic             sval,
    input  logic             cfg_we,
    input  logic [W-1:0]     cfg_pat,
    output logic             hit,
    output logic [CNT_W-1:0] hit_cnt
);
    localparam int FW = $clog2(W + 1);

    logic [W-1:0]  win, win_n, pat;
    logic [FW-1:0] fill, fill_n;
    logic          match;

    // Compare against the window as it will look with this cycle's bit included.
    always_comb begin
        win_n  = {win[W-2:0], sbit};
        fill_n = (fill == FW'(W)) ? fill : fill + FW'(1);
        match  = sval && (win_n == pat) && (fill_n == FW'(W));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            win     <= '0;
            fill    <= '0;
            pat     <= PAT_RST;
            hit     <= 1'b0;
            hit_cnt <= '0;
        end else if (cfg_we) begin
            // new pattern restarts matching; the coincident bit is dropped
            pat     <= cfg_pat;
            fill    <= '0;
            hit     <= 1'b0;
            hit_cnt <= '0;
        end else begin
            hit <= match;
            if (sval) begin
                win  <= win_n;
                fill <= fill_n;
            end
            if (match && (hit_cnt != '1))
                hit_cnt <= hit_cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/seq_scan_ctrl.sv
// Word-to-bit serializer (MSB first, gapless back-to-back) feeding the pattern matcher.
module seq_scan_ctrl
    import seq_pkg::*;
#(
    parameter int           W       = DEF_W,
    parameter int           CNT_W   = DEF_CNT_W,
    parameter logic [W-1:0] PAT_RST = DEF_PAT
) (
    input  logic            CLK,
    input  logic            RST,
    seq_scan_ctrl_if.slave  bus
);
    localparam int BW = (W > 1) ? $clog2(W) : 1;

    state_t        state, state_n;
    logic [W-1:0]  sreg, sreg_n;
    logic [BW-1:0] bcnt, bcnt_n;
    logic          xfer;

    // Ready while idle or while the last bit of the current word is out, so reload is gapless.
    assign bus.IN_READY = (state == IDLE) || (bcnt == '0);
    assign xfer         = bus.IN_VALID && bus.IN_READY;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            sreg  <= '0;
            bcnt  <= '0;
        end else begin
            state <= state_n;
            sreg  <= sreg_n;
            bcnt  <= bcnt_n;
        end
    end

    always_comb begin
        state_n = state;
        sreg_n  = sreg;
        bcnt_n  = bcnt;
        case (state)
            IDLE: begin
                if (xfer) begin
                    sreg_n  = bus.IN_DATA;
                    bcnt_n  = BW'(W - 1);
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                sreg_n = sreg << 1;
                bcnt_n = bcnt - BW'(1);
                if (bcnt == '0) begin
                    if (xfer) begin
                        sreg_n = bus.IN_DATA;
                        bcnt_n = BW'(W - 1);
                    end else begin
                        sreg_n  = '0;
                        bcnt_n  = '0;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.DOUT = sreg[W-1];
    assign bus.DVAL = (state == SHIFT);
    assign bus.BUSY = (state == SHIFT);

    seq_match #(
        .W       (W),
        .CNT_W   (CNT_W),
        .PAT_RST (PAT_RST)
    ) u_match (
        .CLK     (CLK),
        .RST     (RST),
        .sbit    (sreg[W-1]),
        .sval    (state == SHIFT),
        .cfg_we  (bus.CFG_WE),
        .cfg_pat (bus.CFG_PAT),
        .hit     (bus.HIT),
        .hit_cnt (bus.HIT_CNT)
    );
endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed bench for seq_scan_ctrl; per-cycle traces compared against hand-derived bit masks.
module tb_seq_scan_ctrl;
    import seq_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    seq_scan_ctrl_if #(.W(8), .CNT_W(4)) bus ();

    seq_scan_ctrl #(.W(8), .CNT_W(4), .PAT_RST(8'hD3)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    logic [7:0]  wq [8];
    logic [63:0] dv, hv, rv, bv, dq;
    logic [3:0]  hc [64];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Streams n words from wq with a ready-respecting producer for ncyc cycles,
    // optionally pulsing CFG_WE / RST in one cycle; bit c of each trace is cycle c.
    task automatic run(input int n, input int ncyc, input int cfg_c,
                       input logic [7:0] cfg_p, input int rst_c);
        int   idx;
        logic xf;
        idx = 0;
        dv = '0; hv = '0; rv = '0; bv = '0; dq = '0;
        for (int c = 0; c < ncyc; c++) begin
            bus.IN_VALID = (idx < n);
            bus.IN_DATA  = (idx < n) ? wq[idx] : 8'h00;
            bus.CFG_WE   = (c == cfg_c);
            bus.CFG_PAT  = cfg_p;
            rst          = (c == rst_c);
            dv[c] = bus.DVAL;
            hv[c] = bus.HIT;
            rv[c] = bus.IN_READY;
            bv[c] = bus.BUSY;
            dq[c] = bus.DOUT;
            hc[c] = bus.HIT_CNT;
            xf = bus.IN_VALID && bus.IN_READY && !rst;
            cyc();
            if (xf) idx++;
        end
        bus.IN_VALID = 1'b0;
        bus.CFG_WE   = 1'b0;
        rst          = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.IN_VALID = 1'b0; bus.IN_DATA = '0; bus.CFG_WE = 1'b0; bus.CFG_PAT = '0;
        cyc();
        cyc();
        rst = 1'b0;
        checks++; if (bus.DVAL !== 1'b0) begin errors++; $display("FAIL reset_dval got %b exp 0", bus.DVAL); end
        checks++; if (bus.DOUT !== 1'b0) begin errors++; $display("FAIL reset_dout got %b exp 0", bus.DOUT); end
        checks++; if (bus.HIT !== 1'b0) begin errors++; $display("FAIL reset_hit got %b exp 0", bus.HIT); end
        checks++; if (bus.HIT_CNT !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", bus.HIT_CNT); end
        checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.BUSY); end
        checks++; if (bus.IN_READY !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", bus.IN_READY); end
    endtask

    task automatic test_single();
        wq[0] = 8'hD3;
        run(1, 12, -1, 8'h00, -1);
        checks++; if (dv !== 64'h1FE) begin errors++; $display("FAIL single_dval got %h exp %h", dv, 64'h1FE); end
        checks++; if (dq !== 64'h196) begin errors++; $display("FAIL single_dout got %h exp %h", dq, 64'h196); end
        checks++; if (hv !== 64'h200) begin errors++; $display("FAIL single_hit got %h exp %h", hv, 64'h200); end
        checks++; if (rv !== 64'hF01) begin errors++; $display("FAIL single_ready got %h exp %h", rv, 64'hF01); end
        checks++; if (bv !== 64'h1FE) begin errors++; $display("FAIL single_busy got %h exp %h", bv, 64'h1FE); end
        checks++; if (bus.HIT_CNT !== 4'd1) begin errors++; $display("FAIL single_cnt got %0d exp 1", bus.HIT_CNT); end
    endtask

    task automatic test_back_to_back();
        wq[0] = 8'hD3; wq[1] = 8'hD3;
        run(2, 20, 0, 8'hD3, -1);
        checks++; if (dv !== 64'h1FFFE) begin errors++; $display("FAIL b2b_dval got %h exp %h", dv, 64'h1FFFE); end
        checks++; if (rv !== 64'hF0101) begin errors++; $display("FAIL b2b_ready got %h exp %h", rv, 64'hF0101); end
        checks++; if (hv !== 64'h20200) begin errors++; $display("FAIL b2b_hit got %h exp %h", hv, 64'h20200); end
        checks++; if (bus.HIT_CNT !== 4'd2) begin errors++; $display("FAIL b2b_cnt got %0d exp 2", bus.HIT_CNT); end
    endtask

    task automatic test_boundary();
        wq[0] = 8'h0D; wq[1] = 8'h30;
        run(2, 20, 0, 8'hD3, -1);
        checks++; if (hv !== 64'h2000) begin errors++; $display("FAIL boundary_hit got %h exp %h", hv, 64'h2000); end
        checks++; if (bus.HIT_CNT !== 4'd1) begin errors++; $display("FAIL boundary_cnt got %0d exp 1", bus.HIT_CNT); end
    endtask

    task automatic test_overlap();
        wq[0] = 8'hAA; wq[1] = 8'hAA;
        run(2, 20, 0, 8'hAA, -1);
        checks++; if (hv !== 64'h2AA00) begin errors++; $display("FAIL overlap_hit got %h exp %h", hv, 64'h2AA00); end
        checks++; if (bus.HIT_CNT !== 4'd5) begin errors++; $display("FAIL overlap_cnt got %0d exp 5", bus.HIT_CNT); end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 5; i++) wq[i] = 8'hAA;
        run(5, 44, 0, 8'hAA, -1);
        checks++; if ($countones(hv) != 17) begin errors++; $display("FAIL sat_hits got %0d exp 17", $countones(hv)); end
        checks++; if (hv[41] !== 1'b1) begin errors++; $display("FAIL sat_last_hit got %b exp 1", hv[41]); end
        checks++; if (bus.HIT_CNT !== 4'd15) begin errors++; $display("FAIL sat_cnt got %0d exp 15", bus.HIT_CNT); end
    endtask

    task automatic test_cfg_midword();
        wq[0] = 8'hAA; wq[1] = 8'hAA;
        run(2, 20, 5, 8'hAA, -1);
        checks++; if (hc[5] !== 4'd15) begin errors++; $display("FAIL cfg_cnt_before got %0d exp 15", hc[5]); end
        checks++; if (hc[6] !== 4'd0) begin errors++; $display("FAIL cfg_cnt_clear got %0d exp 0", hc[6]); end
        checks++; if (hv !== 64'h28028) begin errors++; $display("FAIL cfg_hit got %h exp %h", hv, 64'h28028); end
        checks++; if (bus.HIT_CNT !== 4'd2) begin errors++; $display("FAIL cfg_cnt got %0d exp 2", bus.HIT_CNT); end
    endtask

    task automatic test_reset_midword();
        wq[0] = 8'hD3;
        run(1, 8, -1, 8'h00, 4);
        checks++; if (dv !== 64'h1E) begin errors++; $display("FAIL rstmid_dval got %h exp %h", dv, 64'h1E); end
        checks++; if (hc[5] !== 4'd0) begin errors++; $display("FAIL rstmid_cnt got %0d exp 0", hc[5]); end
        checks++; if (rv[5] !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b exp 1", rv[5]); end
        checks++; if (bv[5] !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", bv[5]); end
        run(1, 12, -1, 8'h00, -1);
        checks++; if (hv !== 64'h200) begin errors++; $display("FAIL rstmid_hit got %h exp %h", hv, 64'h200); end
        checks++; if (bus.HIT_CNT !== 4'd1) begin errors++; $display("FAIL rstmid_final got %0d exp 1", bus.HIT_CNT); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_boundary();
        test_overlap();
        test_saturate();
        test_cfg_midword();
        test_reset_midword();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
